radar_frame_sequencer: RTL

Frame-level controller for the radar DSP chain. It aligns each processing frame to the chirp ramp, resets and kicks the FFT, and gates averaged samples into the windowing stage for exactly one frame. It then tags FFT magnitude bins for the serial interface and waits for the serial transfer to finish before arming for the next chirp. It sits between the chirp/ADC timing source and the windowing → FFT_Mag → SerialInterface path, in the `clk_div_16` domain.

---
 rtl/radar_frame_sequencer_if.sv | 35 +++
 rtl/radar_frame_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/radar_frame_sequencer_if.sv
// Handshake bundle between the radar frame sequencer and the chirp/ADC, windowing,
// FFT and serial-interface blocks around it.
interface radar_frame_sequencer_if #(
    parameter int unsigned NUM_BINS = 256
);
    localparam int unsigned BIN_W = $clog2(NUM_BINS);

    logic             enable;
    logic             chirp_start;
    logic             sample_valid;
    logic             fft_next_out;
    logic             ser_done;
    logic             win_en;
    logic             fft_reset;
    logic             fft_next;
    logic             out_valid;
    logic [BIN_W-1:0] bin_idx;
    logic             ser_start;
    logic             busy;
    logic [15:0]      frame_count;
    logic             overrun;
    logic             timeout;

    modport master (
        input  enable, chirp_start, sample_valid, fft_next_out, ser_done,
        output win_en, fft_reset, fft_next, out_valid, bin_idx, ser_start,
               busy, frame_count, overrun, timeout
    );

    modport slave (
        output enable, chirp_start, sample_valid, fft_next_out, ser_done,
        input  win_en, fft_reset, fft_next, out_valid, bin_idx, ser_start,
               busy, frame_count, overrun, timeout
    );
endinterface

// File: rtl/radar_frame_sequencer.sv
// Frame-level controller: aligns a DSP frame to the chirp ramp, drives the FFT and
// serial transfer. Define RADAR_SEQ_TIMEOUT_EN to add the WAIT_FFT/SER_WAIT watchdog.
module radar_frame_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned NUM_SAMPLES    = 256,
    parameter int unsigned NUM_BINS       = 256,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic                     clk,
    input  logic                     reset_n,
    radar_frame_sequencer_if.master  bus
);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned SMP_W = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned BIN_W = $clog2(NUM_BINS);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(NUM_SAMPLES - 1);
    localparam logic [BIN_W-1:0] BIN_LAST    = BIN_W'(NUM_BINS - 1);

    // Elaboration-time guard against degenerate configurations
    if (SETTLE_CYCLES < 1 || NUM_SAMPLES < 1 || NUM_BINS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("radar_frame_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_FFT,
        S_SETTLE,
        S_COLLECT,
        S_WAIT_FFT,
        S_STREAM,
        S_SER_START,
        S_SER_WAIT
    } state_t;

    state_t           state;
    logic             rst_phase;
    logic [SET_W-1:0] settle_cnt;
    logic [SMP_W-1:0] sample_cnt;
    logic             win_en_q;
    logic             fft_reset_q;
    logic             fft_next_q;
    logic             out_valid_q;
    logic [BIN_W-1:0] bin_idx_q;
    logic             ser_start_q;
    logic             busy_q;
    logic [15:0]      frame_count_q;
    logic             overrun_q;

`ifdef RADAR_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;
    logic            wd_expired;

    assign wd_expired  = (wd_cnt == WD_LAST);
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            rst_phase     <= 1'b0;
            settle_cnt    <= '0;
            sample_cnt    <= '0;
            win_en_q      <= 1'b0;
            fft_reset_q   <= 1'b0;
            fft_next_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            bin_idx_q     <= '0;
            ser_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
`ifdef RADAR_SEQ_TIMEOUT_EN
            wd_cnt        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            fft_next_q  <= 1'b0;
            ser_start_q <= 1'b0;

            if (state != S_IDLE && bus.chirp_start) begin
                overrun_q <= 1'b1;
            end

`ifdef RADAR_SEQ_TIMEOUT_EN
            // Watchdog restarts whenever the FSM is outside a waiting state
            if (state == S_WAIT_FFT || state == S_SER_WAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
`endif

            case (state)
                S_IDLE: begin
                    if (bus.chirp_start && bus.enable) begin
                        state       <= S_RST_FFT;
                        fft_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        rst_phase   <= 1'b0;
                    end
                end
                S_RST_FFT: begin
                    if (rst_phase) begin
                        fft_reset_q <= 1'b0;
                        settle_cnt  <= '0;
                        state       <= S_SETTLE;
                    end else begin
                        rst_phase <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        fft_next_q <= 1'b1;
                        win_en_q   <= 1'b1;
                        sample_cnt <= '0;
                        state      <= S_COLLECT;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                S_COLLECT: begin
                    if (bus.sample_valid) begin
                        if (sample_cnt == SAMPLE_LAST) begin
                            win_en_q   <= 1'b0;
                            sample_cnt <= '0;
                            state      <= S_WAIT_FFT;
                        end else begin
                            sample_cnt <= sample_cnt + SMP_W'(1);
                        end
                    end
                end
                S_WAIT_FFT: begin
                    if (bus.fft_next_out) begin
                        out_valid_q <= 1'b1;
                        bin_idx_q   <= '0;
                        state       <= S_STREAM;
                    end
`ifdef RADAR_SEQ_TIMEOUT_EN
                    else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end
`endif
                end
                S_STREAM: begin
                    if (bin_idx_q == BIN_LAST) begin
                        out_valid_q <= 1'b0;
                        bin_idx_q   <= '0;
                        ser_start_q <= 1'b1;
                        state       <= S_SER_START;
                    end else begin
                        bin_idx_q <= bin_idx_q + BIN_W'(1);
                    end
                end
                S_SER_START: begin
                    state <= S_SER_WAIT;
                end
                S_SER_WAIT: begin
                    if (bus.ser_done) begin
                        frame_count_q <= frame_count_q + 16'd1;
                        busy_q        <= 1'b0;
                        state         <= S_IDLE;
                    end
`ifdef RADAR_SEQ_TIMEOUT_EN
                    else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.win_en      = win_en_q;
    assign bus.fft_reset   = fft_reset_q;
    assign bus.fft_next    = fft_next_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.bin_idx     = bin_idx_q;
    assign bus.ser_start   = ser_start_q;
    assign bus.busy        = busy_q;
    assign bus.frame_count = frame_count_q;
    assign bus.overrun     = overrun_q;
endmodule
